// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO read-side arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BURST)
//   ch_width()  : width of a channel index, never less than 1 bit
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // A single channel still needs a 1-bit index so that port widths stay legal.
  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational rotating priority encoder. Returns the first requesting index
// found when scanning rr_ptr, rr_ptr+1, ... modulo NumCh.
// Ports:
//   req        : request vector, bit k = channel k
//   rr_ptr     : index with the highest priority this cycle (< NumCh)
//   pick       : selected channel index (0 when nothing requests)
//   pick_valid : at least one request is present
// -----------------------------------------------------------------------------
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NumCh = 4,
  parameter int ChW   = ch_width(NumCh)
) (
  input  logic [NumCh-1:0] req,
  input  logic [ChW-1:0]   rr_ptr,
  output logic [ChW-1:0]   pick,
  output logic             pick_valid
);

  // Scan from the lowest priority position up to rr_ptr so that the position
  // closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      pick       = req[(int'(rr_ptr) + i) % NumCh] ? ChW'((int'(rr_ptr) + i) % NumCh) : pick;
      pick_valid = pick_valid | req[(int'(rr_ptr) + i) % NumCh];
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_read_arbiter
// Drains NumCh FIFO read ports into one valid/ready stream in the clk_rd
// domain. Round-robin arbitration with a burst quantum of MaxBurst pops; a
// popped word appears in the output register one cycle after its o_rd_en.
//
// Build option: FIFO_ARB_CH0_PRIO_EN
//   defined   -> channel 0 is strict priority (wins in IDLE, cuts other
//                channels' bursts after the current pop)
//   undefined -> pure round-robin
//
// Ports:
//   clk_rd    : read-domain clock
//   rst_rd    : synchronous active-high reset
//   i_empty   : per-FIFO registered empty flags
//   i_rd_data : head word of each FIFO, FIFO k at [k*DataWidth +: DataWidth]
//   o_rd_en   : one-hot-or-zero pop strobe, forced low during reset
//   o_valid   : output register holds a word
//   i_ready   : downstream accepts when o_valid & i_ready
//   o_data    : popped word
//   o_chan    : source channel of o_data
//   o_busy    : high while in BURST
// -----------------------------------------------------------------------------
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NumCh     = 4,
  parameter int DataWidth = 8,
  parameter int MaxBurst  = 4,
  parameter int ChW       = ch_width(NumCh)
) (
  input  logic                       clk_rd,
  input  logic                       rst_rd,
  input  logic [NumCh-1:0]           i_empty,
  input  logic [NumCh*DataWidth-1:0] i_rd_data,
  output logic [NumCh-1:0]           o_rd_en,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DataWidth-1:0]       o_data,
  output logic [ChW-1:0]             o_chan,
  output logic                       o_busy
);

  localparam int              BcW      = $clog2(MaxBurst + 1);
  localparam logic [ChW-1:0]  LastCh   = ChW'(NumCh - 1);
  localparam logic [BcW-1:0]  BurstMax = BcW'(MaxBurst);

  arb_state_e       state_r, state_s;
  logic [ChW-1:0]   rr_ptr_r, rr_ptr_s;
  logic [ChW-1:0]   cur_ch_r, cur_ch_s;
  logic [BcW-1:0]   burst_cnt_r, burst_cnt_s;
  logic [BcW-1:0]   burst_inc_s;
  logic             pop_s;
  logic [ChW-1:0]   pop_ch_s;
  logic             can_accept_s;
  logic [ChW-1:0]   pick_raw_s;
  logic [ChW-1:0]   pick_s;
  logic             pick_valid_s;
  logic             prio_cut_s;

  function automatic logic [ChW-1:0] next_ch(input logic [ChW-1:0] ch);
    return (ch == LastCh) ? '0 : ch + ChW'(1);
  endfunction

  // A pop is only allowed when the output register is free or being drained.
  assign can_accept_s = ~o_valid | i_ready;

  rr_picker #(
    .NumCh (NumCh),
    .ChW   (ChW)
  ) u_rr_picker (
    .req        (~i_empty),
    .rr_ptr     (rr_ptr_r),
    .pick       (pick_raw_s),
    .pick_valid (pick_valid_s)
  );

`ifdef FIFO_ARB_CH0_PRIO_EN
  // Channel 0 overrides the rotation; pick_valid is already set when it requests.
  assign pick_s     = i_empty[0] ? pick_raw_s : '0;
  assign prio_cut_s = ~i_empty[0] & (cur_ch_r != '0);
`else
  assign pick_s     = pick_raw_s;
  assign prio_cut_s = 1'b0;
`endif

  assign o_busy = (state_r == BURST);

  // Next-state, pop decision and pointer/counter updates.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    cur_ch_s    = cur_ch_r;
    burst_cnt_s = burst_cnt_r;
    burst_inc_s = burst_cnt_r + BcW'(1);
    pop_s       = 1'b0;
    pop_ch_s    = cur_ch_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s && can_accept_s) begin
          pop_s       = 1'b1;
          pop_ch_s    = pick_s;
          cur_ch_s    = pick_s;
          burst_cnt_s = BcW'(1);
          // A quantum of one never enters BURST; rotate immediately.
          if (MaxBurst == 1) begin
            rr_ptr_s = next_ch(pick_s);
          end else begin
            state_s = BURST;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (i_empty[cur_ch_r]) begin
          state_s  = IDLE;
          rr_ptr_s = next_ch(cur_ch_r);
        end else if (!can_accept_s) begin
          state_s = BURST;
        end else begin
          pop_s       = 1'b1;
          burst_cnt_s = burst_inc_s;
          if ((burst_inc_s == BurstMax) || prio_cut_s) begin
            state_s  = IDLE;
            rr_ptr_s = next_ch(cur_ch_r);
          end else begin
            state_s = BURST;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Pop strobe decode; suppressed while reset is asserted.
  always_comb begin
    o_rd_en = '0;
    if (pop_s && !rst_rd) begin
      o_rd_en[pop_ch_s] = 1'b1;
    end else begin
      o_rd_en = '0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      cur_ch_r    <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      cur_ch_r    <= cur_ch_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

  // Output register: load on pop, clear when drained, otherwise hold.
  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
    end else if (pop_s) begin
      o_valid <= 1'b1;
      o_data  <= i_rd_data[int'(pop_ch_s) * DataWidth +: DataWidth];
      o_chan  <= pop_ch_s;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= o_valid;
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_arbiter
// Directed bench for fifo_read_arbiter (NumCh=4, DataWidth=8, MaxBurst=4).
// FIFO k is modelled by a head index and a word count; word i of FIFO k
// carries the value k*16+i so every popped word identifies its origin.
// -----------------------------------------------------------------------------
module tb_fifo_read_arbiter;

  logic        clk_rd = 1'b0;
  logic        rst_rd = 1'b1;
  logic [3:0]  i_empty;
  logic [31:0] i_rd_data;
  logic [3:0]  o_rd_en;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [7:0]  o_data;
  logic [1:0]  o_chan;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;
  int head[4]   = '{0, 0, 0, 0};
  int cnt[4]    = '{0, 0, 0, 0};
  int sb_idx[4] = '{0, 0, 0, 0};
  logic [3:0] last_en;
  logic [7:0] last_word;

  always #5 clk_rd = ~clk_rd;

  fifo_read_arbiter #(
    .NumCh     (4),
    .DataWidth (8),
    .MaxBurst  (4)
  ) dut (
    .clk_rd    (clk_rd),
    .rst_rd    (rst_rd),
    .i_empty   (i_empty),
    .i_rd_data (i_rd_data),
    .o_rd_en   (o_rd_en),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_chan    (o_chan),
    .o_busy    (o_busy)
  );

  function automatic logic [7:0] word(input int k, input int i);
    return 8'(k * 16 + i);
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] v);
    case (v)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic drive_fifos();
    for (int k = 0; k < 4; k++) begin
      i_empty[k]         = (cnt[k] == 0);
      i_rd_data[k*8 +: 8] = word(k, head[k]);
    end
  endtask

  task automatic load(input int k, input int n);
    cnt[k] = cnt[k] + n;
    drive_fifos();
  endtask

  // One clock: sample strobes and accepted word at negedge, apply pops after posedge.
  task automatic tick();
    @(negedge clk_rd);
    last_en = o_rd_en;
    if (o_valid && i_ready && !rst_rd) begin
      checks++;
      if (o_data !== word(int'(o_chan), sb_idx[o_chan])) begin
        failures++;
        $display("FAIL scoreboard ch=%0d got=%h exp=%h", o_chan, o_data, word(int'(o_chan), sb_idx[o_chan]));
      end
      sb_idx[o_chan]++;
    end
    @(posedge clk_rd);
    #1;
    last_word = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (last_en[k]) begin
        checks++;
        if (cnt[k] == 0) begin
          failures++;
          $display("FAIL pop_of_empty ch=%0d got=rd_en exp=no_rd_en", k);
        end else begin
          last_word = word(k, head[k]);
          head[k]++;
          cnt[k]--;
        end
      end
    end
    drive_fifos();
  endtask

  task automatic do_reset();
    rst_rd  = 1'b1;
    i_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      head[k]   = 0;
      cnt[k]    = 0;
      sb_idx[k] = 0;
    end
    drive_fifos();
    rst_rd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 4);
    rst_rd = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (last_en !== 4'b0000 || o_valid !== 1'b0 || o_chan !== 2'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got en=%b v=%b ch=%0d exp en=0000 v=0 ch=0", c, last_en, o_valid, o_chan);
      end
    end
    rst_rd = 1'b0;
    tick();
    checks++;
    if (last_en !== 4'b0001 || o_valid !== 1'b1 || o_data !== word(0, 0) || o_chan !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_pop got en=%b v=%b d=%h exp en=0001 v=1 d=%h", last_en, o_valid, o_data, word(0, 0));
    end
    tick();
    checks++;
    if (last_en !== 4'b0001 || o_data !== word(0, 1) || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_second_pop got en=%b d=%h busy=%b exp en=0001 d=%h busy=1", last_en, o_data, o_busy, word(0, 1));
    end
    rst_rd = 1'b1;
    tick();
    checks++;
    if (last_en !== 4'b0000 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_burst got en=%b v=%b busy=%b exp en=0000 v=0 busy=0", last_en, o_valid, o_busy);
    end
    rst_rd = 1'b0;
    for (int k = 0; k < 4; k++) sb_idx[k] = head[k];
    tick();
    checks++;
    if (last_en !== 4'b0001 || o_data !== word(0, 2) || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_restart got en=%b d=%h busy=%b exp en=0001 d=%h busy=1", last_en, o_data, o_busy, word(0, 2));
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp [20] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                             4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
                             4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 10);
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (last_en !== exp[c] || o_valid !== 1'b1 || o_chan !== enc(exp[c]) || o_data !== last_word) begin
        failures++;
        $display("FAIL rr cyc=%0d got en=%b v=%b ch=%0d d=%h exp en=%b v=1 ch=%0d d=%h",
                 c, last_en, o_valid, o_chan, o_data, exp[c], enc(exp[c]), last_word);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] exp [12] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                             4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    do_reset();
    load(0, 1);
    load(1, 2);
    load(2, 5);
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (last_en !== exp[c]) begin
        failures++;
        $display("FAIL early_en cyc=%0d got=%b exp=%b", c, last_en, exp[c]);
      end
      checks++;
      if (exp[c] != 4'b0000) begin
        if (o_valid !== 1'b1 || o_chan !== enc(exp[c]) || o_data !== last_word) begin
          failures++;
          $display("FAIL early_out cyc=%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                   c, o_valid, o_chan, o_data, enc(exp[c]), last_word);
        end
      end else if (o_valid !== 1'b0) begin
        failures++;
        $display("FAIL early_idle cyc=%0d got v=%b exp v=0", c, o_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp [14] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic       rdy [14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    load(1, 8);
    for (int c = 0; c < 14; c++) begin
      i_ready = rdy[c];
      tick();
      checks++;
      if (last_en !== exp[c]) begin
        failures++;
        $display("FAIL bp_en cyc=%0d got=%b exp=%b", c, last_en, exp[c]);
      end
      checks++;
      if (exp[c] != 4'b0000) begin
        if (o_valid !== 1'b1 || o_chan !== 2'd1 || o_data !== last_word) begin
          failures++;
          $display("FAIL bp_out cyc=%0d got v=%b ch=%0d d=%h exp v=1 ch=1 d=%h", c, o_valid, o_chan, o_data, last_word);
        end
      end else if (!rdy[c]) begin
        if (o_valid !== 1'b1 || o_data !== word(1, 1)) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got v=%b d=%h exp v=1 d=%h", c, o_valid, o_data, word(1, 1));
        end
      end else if (o_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_drain cyc=%0d got v=%b exp v=0", c, o_valid);
      end
    end
    i_ready = 1'b1;
    checks++;
    if (sb_idx[1] != 8) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=8", sb_idx[1]);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp [13] = '{4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001,
                             4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    load(2, 1);
    for (int c = 0; c < 13; c++) begin
      if (c == 2) begin
        load(3, 2);
        load(0, 3);
      end
      if (c == 9) begin
        load(0, 1);
        load(1, 1);
      end
      tick();
      checks++;
      if (last_en !== exp[c]) begin
        failures++;
        $display("FAIL wrap_en cyc=%0d got=%b exp=%b", c, last_en, exp[c]);
      end
      if (exp[c] != 4'b0000) begin
        checks++;
        if (o_chan !== enc(exp[c]) || o_data !== last_word) begin
          failures++;
          $display("FAIL wrap_out cyc=%0d got ch=%0d d=%h exp ch=%0d d=%h", c, o_chan, o_data, enc(exp[c]), last_word);
        end
      end
    end
  endtask

  task automatic test_ch0_late();
`ifdef FIFO_ARB_CH0_PRIO_EN
    logic [3:0] exp [10] = '{4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0000,
                             4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
`else
    logic [3:0] exp [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001,
                             4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
`endif
    do_reset();
    load(2, 5);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) load(0, 2);
      tick();
      checks++;
      if (last_en !== exp[c]) begin
        failures++;
        $display("FAIL ch0_late_en cyc=%0d got=%b exp=%b", c, last_en, exp[c]);
      end
      if (exp[c] != 4'b0000) begin
        checks++;
        if (o_chan !== enc(exp[c]) || o_data !== last_word) begin
          failures++;
          $display("FAIL ch0_late_out cyc=%0d got ch=%0d d=%h exp ch=%0d d=%h", c, o_chan, o_data, enc(exp[c]), last_word);
        end
      end
    end
  endtask

  initial begin
    drive_fifos();
    test_reset();
`ifndef FIFO_ARB_CH0_PRIO_EN
    test_round_robin();
    test_wrap();
`endif
    test_early_release();
    test_backpressure();
    test_ch0_late();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
